// File: rtl/kbd_matrix_inject.sv
// ---------------------------------------------------------------------------
// kbd_matrix_inject
//
// Keyboard-matrix emulator with a timed key-injection queue. A live
// ROWS x COLS key matrix is maintained from pre-mapped press/release events.
// A FIFO-fed sequencer overlays one injected key (optionally with SHIFT) for
// a fixed hold time, followed by a fixed release gap, so that pasted text or
// autotype strings can be replayed into the emulated machine. The CPU drives
// active-low column selects and reads back a registered set of active-high
// pressed rows.
//
// Ports:
//   clk_sys    system clock, all state changes on its rising edge
//   reset      asynchronous active-high reset, clears all state
//   clear      synchronous release of every live key
//   ev_valid   one-cycle live key event strobe
//   ev_press   1 = press, 0 = release
//   ev_row     live event row
//   ev_col     live event column
//   col_sel    active-low column drive from the CPU port
//   rows       registered active-high pressed rows for the selected columns
//   inj_valid  injection push request
//   inj_ready  injection queue not full
//   inj_shift  hold SHIFT together with the injected key
//   inj_row    injected key row
//   inj_col    injected key column
//   inj_flush  synchronous queue empty and sequence abort
//   inj_busy   queue non-empty or sequencer active
// ---------------------------------------------------------------------------
module kbd_matrix_inject #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int FIFO_DEPTH  = 16,
  parameter int HOLD_CYCLES = 100000,
  parameter int GAP_CYCLES  = 100000,
  parameter int SHIFT_ROW   = 6,
  parameter int SHIFT_COL   = 7,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic            clk_sys,
  input  logic            reset,
  input  logic            clear,
  input  logic            ev_valid,
  input  logic            ev_press,
  input  logic [RW-1:0]   ev_row,
  input  logic [CW-1:0]   ev_col,
  input  logic [COLS-1:0] col_sel,
  output logic [ROWS-1:0] rows,
  input  logic            inj_valid,
  output logic            inj_ready,
  input  logic            inj_shift,
  input  logic [RW-1:0]   inj_row,
  input  logic [CW-1:0]   inj_col,
  input  logic            inj_flush,
  output logic            inj_busy
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int EW      = 1 + RW + CW;
  localparam int CNT_MAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  localparam logic [AW:0]     COUNT_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0]     COUNT_FULL = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW-1:0]   PTR_ONE   = {{(AW - 1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] CNT_ONE   = {{(CNTW - 1){1'b0}}, 1'b1};
  localparam logic [CNTW-1:0] HOLD_LOAD = CNTW'(HOLD_CYCLES - 1);
  localparam logic [CNTW-1:0] GAP_LOAD  = CNTW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESS,
    ST_GAP
  } seqState_e;

  // Live and injected key matrices, registered scan output
  logic [ROWS-1:0][COLS-1:0] liveQ, liveD;
  logic [ROWS-1:0][COLS-1:0] injQ, injD;
  logic [ROWS-1:0][COLS-1:0] effective;
  logic [ROWS-1:0][COLS-1:0] popMatrix;
  logic [ROWS-1:0]           rowsQ, rowsD;

  // Sequencer
  seqState_e                 stateQ, stateD;
  logic [CNTW-1:0]           cntQ, cntD;

  // Injection FIFO
  logic [EW-1:0]             fifoMem [FIFO_DEPTH];
  logic [AW-1:0]             wrPtrQ, wrPtrD;
  logic [AW-1:0]             rdPtrQ, rdPtrD;
  logic [AW:0]               countQ, countD;
  logic [EW-1:0]             popEntry;
  logic                      popShift;
  logic [RW-1:0]             popRow;
  logic [CW-1:0]             popCol;
  logic                      push;
  logic                      pop;

  // Queue status is derived straight from registered count and state so the
  // producer sees it without any extra cycle of latency.
  assign inj_ready = (countQ != COUNT_FULL);
  assign inj_busy  = (countQ != '0) || (stateQ != ST_IDLE);
  assign rows      = rowsQ;

  // A flush discards any same-cycle push; a pop only happens while the
  // sequencer is idle and there is something queued.
  assign push = inj_valid && inj_ready && !inj_flush;
  assign pop  = (stateQ == ST_IDLE) && (countQ != '0) && !inj_flush;

  assign popEntry = fifoMem[rdPtrQ];
  assign popShift = popEntry[EW-1];
  assign popRow   = popEntry[RW+CW-1:CW];
  assign popCol   = popEntry[CW-1:0];

  // Live matrix update. Matching every cell against the event coordinates
  // means out-of-range rows/columns simply never match and are ignored.
  // clear takes priority over any event arriving in the same cycle.
  always_comb begin
    liveD = liveQ;
    if (clear) begin
      liveD = '0;
    end else if (ev_valid) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int c = 0; c < COLS; c++) begin
          if ((ev_row == RW'(r)) && (ev_col == CW'(c))) begin
            liveD[r][c] = ev_press;
          end
        end
      end
    end
  end

  // Matrix image of the FIFO head entry: the key itself plus SHIFT when
  // flagged. An out-of-range key or SHIFT position yields no asserted bit,
  // so such entries still consume their full time slot silently.
  always_comb begin
    popMatrix = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if ((popRow == RW'(r)) && (popCol == CW'(c))) begin
          popMatrix[r][c] = 1'b1;
        end
        if (popShift && (r == SHIFT_ROW) && (c == SHIFT_COL)) begin
          popMatrix[r][c] = 1'b1;
        end
      end
    end
  end

  // Column scan: each row reports whether any selected (low) column has a
  // pressed key in the combined live + injected matrix.
  always_comb begin
    effective = liveQ | injQ;
    rowsD     = '0;
    for (int r = 0; r < ROWS; r++) begin
      rowsD[r] = |(effective[r] & ~col_sel);
    end
  end

  // FIFO pointer and occupancy bookkeeping. A simultaneous push and pop
  // leaves the count unchanged; flush returns everything to empty.
  always_comb begin
    wrPtrD = wrPtrQ;
    rdPtrD = rdPtrQ;
    countD = countQ;
    if (inj_flush) begin
      wrPtrD = '0;
      rdPtrD = '0;
      countD = '0;
    end else begin
      if (push) begin
        wrPtrD = wrPtrQ + PTR_ONE;
      end
      if (pop) begin
        rdPtrD = rdPtrQ + PTR_ONE;
      end
      if (push && !pop) begin
        countD = countQ + COUNT_ONE;
      end else if (pop && !push) begin
        countD = countQ - COUNT_ONE;
      end
    end
  end

  // Sequencer next state. IDLE pops and asserts the key, PRESS counts down
  // the hold time and then drops the key, GAP counts down the release time.
  // Loading N-1 and leaving on zero gives exactly N cycles in each phase.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    injD   = injQ;
    if (inj_flush) begin
      stateD = ST_IDLE;
      cntD   = '0;
      injD   = '0;
    end else begin
      unique case (stateQ)
        ST_IDLE: begin
          if (countQ != '0) begin
            cntD   = HOLD_LOAD;
            injD   = popMatrix;
            stateD = ST_PRESS;
          end
        end
        ST_PRESS: begin
          if (cntQ == '0) begin
            injD   = '0;
            cntD   = GAP_LOAD;
            stateD = ST_GAP;
          end else begin
            cntD = cntQ - CNT_ONE;
          end
        end
        ST_GAP: begin
          if (cntQ == '0) begin
            stateD = ST_IDLE;
          end else begin
            cntD = cntQ - CNT_ONE;
          end
        end
        default: begin
          stateD = ST_IDLE;
          cntD   = '0;
          injD   = '0;
        end
      endcase
    end
  end

  // All control state lives here. Reset is asynchronous, so an injected key
  // and the registered rows drop immediately when reset is asserted.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      liveQ  <= '0;
      injQ   <= '0;
      rowsQ  <= '0;
      stateQ <= ST_IDLE;
      cntQ   <= '0;
      wrPtrQ <= '0;
      rdPtrQ <= '0;
      countQ <= '0;
    end else begin
      liveQ  <= liveD;
      injQ   <= injD;
      rowsQ  <= rowsD;
      stateQ <= stateD;
      cntQ   <= cntD;
      wrPtrQ <= wrPtrD;
      rdPtrQ <= rdPtrD;
      countQ <= countD;
    end
  end

  // Queue storage needs no reset: the pointers and count define which
  // entries are meaningful.
  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifoMem[wrPtrQ] <= {inj_shift, inj_row, inj_col};
    end
  end

endmodule
